// File: rtl/rpn_gw_pkg.sv
// rpn_gw_pkg: shared AXIS widths and arbiter/source enums for the RPN gateway splitter and merger
package rpn_gw_pkg;
  localparam int RPN_AXIS_DATA_W  = 512;
  localparam int RPN_AXIS_KEEP_W  = RPN_AXIS_DATA_W / 8;
  localparam int RPN_IP_PORT_W    = 16;
  localparam int RPN_AXIS_TUSER_W = 64;
  typedef enum logic [1:0] {IDLE, LOCK_LAN, LOCK_WAN} arb_state_t;
  typedef enum logic {SRC_LAN, SRC_WAN} src_t;
  function automatic arb_state_t lock_of(src_t s);
    return s == SRC_WAN ? LOCK_WAN : LOCK_LAN;
  endfunction
endpackage

// File: rtl/rpn_gw_axis_reg_slice.sv
// rpn_gw_axis_reg_slice: single-entry AXIS output register, loads whenever its slot is free
module rpn_gw_axis_reg_slice #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 16,
  parameter int DEST_W = 16,
  parameter int USER_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  output logic              slot_free,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic [DEST_W-1:0] out_dest,
  output logic [USER_W-1:0] out_user,
  output logic              out_last
);
  assign slot_free = !out_valid || out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_id    <= '0;
      out_dest  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (slot_free) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_keep <= in_keep;
        out_id   <= in_id;
        out_dest <= in_dest;
        out_user <= in_user;
        out_last <= in_last;
      end
    end
  end
endmodule

// File: rtl/rpn_gw_to_network_bridge_merger.sv
// rpn_gw_to_network_bridge_merger: packet-granular round-robin merge of RPN LAN RX and WAN TX streams
module rpn_gw_to_network_bridge_merger
  import rpn_gw_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = RPN_AXIS_DATA_W,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int IP_PORT_WIDTH    = RPN_IP_PORT_W,
  parameter int AXIS_TUSER_WIDTH = RPN_AXIS_TUSER_W
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst,
  input  logic                        from_rpn_LAN_RX_tvalid,
  output logic                        from_rpn_LAN_RX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_LAN_RX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_LAN_RX_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_LAN_RX_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_LAN_RX_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_LAN_RX_tuser,
  input  logic                        from_rpn_LAN_RX_tlast,
  input  logic                        from_rpn_WAN_TX_tvalid,
  output logic                        from_rpn_WAN_TX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_WAN_TX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_WAN_TX_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_WAN_TX_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_WAN_TX_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_WAN_TX_tuser,
  input  logic                        from_rpn_WAN_TX_tlast,
  output logic                        to_network_bridge_tvalid,
  input  logic                        to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tid,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                        to_network_bridge_tlast,
  output logic [31:0]                 o_lan_pkt_count,
  output logic [31:0]                 o_wan_pkt_count
);
  arb_state_t state;
  src_t sel;
  logic wan_turn;
  logic gnt_lan, gnt_wan, slot_free, in_valid, in_last, acc;
  logic [AXIS_DATA_WIDTH-1:0] in_data;
  logic [AXIS_KEEP_WIDTH-1:0] in_keep;
  logic [IP_PORT_WIDTH-1:0] in_id, in_dest;
  logic [AXIS_TUSER_WIDTH-1:0] in_user;
  logic [31:0] lan_cnt, wan_cnt;
  // wan_turn rises after a LAN packet and falls after a WAN one; its reset value gives LAN first priority
  always_comb begin
    gnt_lan = state == LOCK_LAN || (state == IDLE && from_rpn_LAN_RX_tvalid && (!from_rpn_WAN_TX_tvalid || !wan_turn));
    gnt_wan = state == LOCK_WAN || (state == IDLE && from_rpn_WAN_TX_tvalid && (!from_rpn_LAN_RX_tvalid || wan_turn));
    sel = gnt_wan ? SRC_WAN : SRC_LAN;
    in_valid = gnt_wan ? from_rpn_WAN_TX_tvalid : gnt_lan && from_rpn_LAN_RX_tvalid;
    in_data = gnt_wan ? from_rpn_WAN_TX_tdata : from_rpn_LAN_RX_tdata;
    in_keep = gnt_wan ? from_rpn_WAN_TX_tkeep : from_rpn_LAN_RX_tkeep;
    in_id = gnt_wan ? from_rpn_WAN_TX_tid : from_rpn_LAN_RX_tid;
    in_dest = gnt_wan ? from_rpn_WAN_TX_tdest : from_rpn_LAN_RX_tdest;
    in_user = gnt_wan ? from_rpn_WAN_TX_tuser : from_rpn_LAN_RX_tuser;
    in_last = gnt_wan ? from_rpn_WAN_TX_tlast : from_rpn_LAN_RX_tlast;
    acc = in_valid && slot_free;
    from_rpn_LAN_RX_tready = gnt_lan && slot_free && !i_ap_rst;
    from_rpn_WAN_TX_tready = gnt_wan && slot_free && !i_ap_rst;
  end
  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state <= IDLE;
      wan_turn <= 1'b0;
      lan_cnt <= '0;
      wan_cnt <= '0;
    end else if (acc) begin
      if (in_last) begin
        state <= IDLE;
        wan_turn <= sel == SRC_LAN;
        if (sel == SRC_WAN) wan_cnt <= wan_cnt + 32'd1;
        else lan_cnt <= lan_cnt + 32'd1;
      end else begin
        state <= lock_of(sel);
      end
    end
  end
  assign o_lan_pkt_count = lan_cnt;
  assign o_wan_pkt_count = wan_cnt;
  rpn_gw_axis_reg_slice #(
    .DATA_W(AXIS_DATA_WIDTH),
    .KEEP_W(AXIS_KEEP_WIDTH),
    .ID_W(IP_PORT_WIDTH),
    .DEST_W(IP_PORT_WIDTH),
    .USER_W(AXIS_TUSER_WIDTH)
  ) u_out_slice (
    .clk(i_clk),
    .rst(i_ap_rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_keep(in_keep),
    .in_id(in_id),
    .in_dest(in_dest),
    .in_user(in_user),
    .in_last(in_last),
    .slot_free(slot_free),
    .out_valid(to_network_bridge_tvalid),
    .out_ready(to_network_bridge_tready),
    .out_data(to_network_bridge_tdata),
    .out_keep(to_network_bridge_tkeep),
    .out_id(to_network_bridge_tid),
    .out_dest(to_network_bridge_tdest),
    .out_user(to_network_bridge_tuser),
    .out_last(to_network_bridge_tlast)
  );
endmodule

// File: tb/tb_rpn_gw_to_network_bridge_merger.sv
// tb_rpn_gw_to_network_bridge_merger: directed plus randomized checks against a packet-level scoreboard model
module tb_rpn_gw_to_network_bridge_merger;
  typedef struct packed {logic [31:0] tag; logic last;} beat_t;
  logic i_clk = 1'b0, i_ap_rst = 1'b0, sink_ready = 1'b0;
  logic lan_valid, lan_ready, lan_last, wan_valid, wan_ready, wan_last;
  logic [511:0] lan_data, wan_data, out_data;
  logic [63:0] lan_keep, wan_keep, out_keep, lan_user, wan_user, out_user;
  logic [15:0] lan_id, lan_dest, wan_id, wan_dest, out_id, out_dest;
  logic out_valid, out_last;
  logic [31:0] lan_cnt, wan_cnt;
  logic [672:0] cur_fields, snap;
  assign cur_fields = {out_data, out_keep, out_id, out_dest, out_user, out_last};
  always #5 i_clk = ~i_clk;
  rpn_gw_to_network_bridge_merger dut (
    .i_clk(i_clk), .i_ap_rst(i_ap_rst),
    .from_rpn_LAN_RX_tvalid(lan_valid), .from_rpn_LAN_RX_tready(lan_ready), .from_rpn_LAN_RX_tdata(lan_data),
    .from_rpn_LAN_RX_tkeep(lan_keep), .from_rpn_LAN_RX_tid(lan_id), .from_rpn_LAN_RX_tdest(lan_dest),
    .from_rpn_LAN_RX_tuser(lan_user), .from_rpn_LAN_RX_tlast(lan_last),
    .from_rpn_WAN_TX_tvalid(wan_valid), .from_rpn_WAN_TX_tready(wan_ready), .from_rpn_WAN_TX_tdata(wan_data),
    .from_rpn_WAN_TX_tkeep(wan_keep), .from_rpn_WAN_TX_tid(wan_id), .from_rpn_WAN_TX_tdest(wan_dest),
    .from_rpn_WAN_TX_tuser(wan_user), .from_rpn_WAN_TX_tlast(wan_last),
    .to_network_bridge_tvalid(out_valid), .to_network_bridge_tready(sink_ready), .to_network_bridge_tdata(out_data),
    .to_network_bridge_tkeep(out_keep), .to_network_bridge_tid(out_id), .to_network_bridge_tdest(out_dest),
    .to_network_bridge_tuser(out_user), .to_network_bridge_tlast(out_last),
    .o_lan_pkt_count(lan_cnt), .o_wan_pkt_count(wan_cnt)
  );
  int vectors = 0, miscompares = 0, cyc = 0, pkt_id = 0;
  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  logic [31:0] plan[2][$];
  logic [31:0] out_log[$];
  int out_cyc[$];
  logic [31:0] exp_cnt[2];
  bit v[2], en[2];
  bit exp_ov, locked, hold_prev, out_in_pkt;
  int lock_src, last_served, out_src;
  int start_cyc[2], end_cyc[2];

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit fields_ok(logic [31:0] t, logic l);
    return out_data === {16{t}} && out_keep === {2{t}} && out_id === t[15:0] &&
           out_dest === t[31:16] && out_user === {t, ~t} && out_last === l;
  endfunction

  task automatic push_pkt(int s, int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.tag = {s[0], pkt_id[22:0], i[7:0]};
      b.last = i == len - 1;
      src_q[s].push_back(b);
      plan[s].push_back(b.tag);
    end
    pkt_id++;
  endtask

  task automatic apply();
    beat_t b0, b1;
    b0 = '0;
    b1 = '0;
    if (v[0]) b0 = src_q[0][0];
    if (v[1]) b1 = src_q[1][0];
    lan_valid = v[0]; lan_data = {16{b0.tag}}; lan_keep = {2{b0.tag}}; lan_id = b0.tag[15:0];
    lan_dest = b0.tag[31:16]; lan_user = {b0.tag, ~b0.tag}; lan_last = b0.last;
    wan_valid = v[1]; wan_data = {16{b1.tag}}; wan_keep = {2{b1.tag}}; wan_id = b1.tag[15:0];
    wan_dest = b1.tag[31:16]; wan_user = {b1.tag, ~b1.tag}; wan_last = b1.last;
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge
  task automatic step();
    bit sf;
    bit acc[2];
    int owner, s;
    beat_t b;
    for (int k = 0; k < 2; k++) if (!v[k]) v[k] = en[k] && src_q[k].size() > 0;
    apply();
    @(negedge i_clk);
    cyc++;
    sf = !exp_ov || sink_ready;
    owner = locked ? lock_src : (v[0] && v[1]) ? (last_served == 1 ? 0 : 1) : v[0] ? 0 : v[1] ? 1 : -1;
    check("lan_ready", 64'(lan_ready), 64'(sf && owner == 0));
    check("wan_ready", 64'(wan_ready), 64'(sf && owner == 1));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("lan_cnt", lan_cnt, exp_cnt[0]);
    check("wan_cnt", wan_cnt, exp_cnt[1]);
    if (hold_prev) check("stall_hold", 64'(cur_fields === snap), 64'd1);
    if (out_valid && sink_ready) begin
      s = int'(out_data[31]);
      check("beat_expected", 64'(exp_q[s].size() > 0), 64'd1);
      if (exp_q[s].size() > 0) begin
        b = exp_q[s].pop_front();
        check("beat_tag", out_data[31:0], b.tag);
        check("beat_fields", 64'(fields_ok(b.tag, b.last)), 64'd1);
        if (out_in_pkt) check("no_interleave", 64'(s), 64'(out_src));
        out_in_pkt = !b.last;
        out_src = s;
      end
      out_log.push_back(out_data[31:0]);
      out_cyc.push_back(cyc);
    end
    hold_prev = out_valid && !sink_ready;
    snap = cur_fields;
    acc[0] = v[0] && lan_ready;
    acc[1] = v[1] && wan_ready;
    for (int k = 0; k < 2; k++) if (acc[k]) begin
      b = src_q[k].pop_front();
      exp_q[k].push_back(b);
      v[k] = 1'b0;
      if (b.tag[7:0] == 8'd0) start_cyc[k] = cyc;
      if (b.last) begin
        exp_cnt[k]++;
        locked = 1'b0;
        last_served = k;
        end_cyc[k] = cyc;
      end else begin
        locked = 1'b1;
        lock_src = k;
      end
    end
    exp_ov = acc[0] || acc[1] || (exp_ov && !sink_ready);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_ap_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; en[k] = 1'b0; exp_cnt[k] = '0;
      src_q[k].delete(); exp_q[k].delete(); plan[k].delete();
    end
    exp_ov = 0; locked = 0; hold_prev = 0; out_in_pkt = 0; last_served = 1;
    apply();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fields", 64'(cur_fields === '0), 64'd1);
    check("rst_lan_ready", 64'(lan_ready), 64'd0);
    check("rst_wan_ready", 64'(wan_ready), 64'd0);
    check("rst_lan_cnt", lan_cnt, 64'd0);
    check("rst_wan_cnt", wan_cnt, 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_ap_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit ready_pat[7] = '{1, 1, 0, 0, 1, 1, 1};
    int src_i, idx_i, n;
    #1;
    do_reset();
    // single 3-beat LAN packet, one-cycle latency, back-to-back beats
    sink_ready = 1; en = '{1, 1}; out_log.delete(); out_cyc.delete();
    push_pkt(0, 3);
    repeat (5) step();
    check("t1_beats", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("t1_tag", out_log[i], plan[0][i]);
    check("t1_tlast_count", lan_cnt, 1);
    // both sources busy from the start: alternating packets, no gap
    do_reset();
    sink_ready = 1; en = '{1, 1}; out_log.delete(); out_cyc.delete();
    push_pkt(0, 2); push_pkt(1, 2); push_pkt(0, 2); push_pkt(1, 2);
    repeat (10) step();
    check("t2_beats", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      src_i = (i / 2) % 2;
      idx_i = (i / 4) * 2 + i % 2;
      check("t2_order", out_log[i], plan[src_i][idx_i]);
    end
    if (out_cyc.size() == 8) check("t2_no_gap", out_cyc[7] - out_cyc[0], 7);
    // WAN holds the lock while LAN waits
    en = '{0, 1}; out_log.delete();
    push_pkt(1, 4);
    step();
    en = '{1, 1};
    push_pkt(0, 2);
    repeat (8) step();
    check("t3_switch_cycle", start_cyc[0] - end_cyc[1], 1);
    check("t3_beats", out_log.size(), 6);
    // sink stalls mid-packet
    out_log.delete(); plan[0].delete();
    push_pkt(0, 3);
    for (int i = 0; i < 7; i++) begin
      sink_ready = ready_pat[i];
      step();
    end
    check("t4_beats", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("t4_tag", out_log[i], plan[0][i]);
    // async reset mid WAN packet, then LAN goes first
    sink_ready = 1;
    push_pkt(1, 4);
    en = '{0, 1};
    repeat (2) step();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    do_reset();
    out_log.delete();
    push_pkt(1, 1); push_pkt(0, 1);
    en = '{1, 1}; sink_ready = 1;
    repeat (4) step();
    check("t5_beats", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("t5_lan_first", out_log[0], plan[0][0]);
      check("t5_wan_second", out_log[1], plan[1][0]);
    end
    // WAN counter wrap
    force dut.wan_cnt = 32'hFFFF_FFFF;
    exp_cnt[1] = 32'hFFFF_FFFF;
    #1;
    release dut.wan_cnt;
    push_pkt(1, 2);
    repeat (4) step();
    check("t6_wrap", wan_cnt, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (src_q[k].size() < 3) push_pkt(k, 1 + $urandom_range(3));
        en[k] = $urandom_range(3) != 0;
      end
      sink_ready = $urandom_range(3) != 0;
      step();
    end
    en = '{1, 1}; sink_ready = 1; n = 0;
    while (n < 200 && (src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) > 0) begin
      step();
      n++;
    end
    check("drain_lan", exp_q[0].size() + src_q[0].size(), 0);
    check("drain_wan", exp_q[1].size() + src_q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
